// File: rtl/cpc_bus_pkg.sv
// Shared encodings for the CPC expansion-bus initiator: request ops, FSM states
// and the fixed bus addresses it drives.
package cpc_bus_pkg;

    typedef enum logic [1:0] {
        OP_SEL     = 2'd0,
        OP_READ    = 2'd1,
        OP_SELREAD = 2'd2
    } cpc_op_e;

    typedef enum logic [3:0] {
        IDLE  = 4'd0,
        IO_T1 = 4'd1,
        IO_T2 = 4'd2,
        IO_TW = 4'd3,
        IO_T3 = 4'd4,
        MR_T1 = 4'd5,
        MR_T2 = 4'd6,
        MR_TW = 4'd7,
        MR_T3 = 4'd8,
        DONE  = 4'd9
    } cpc_state_e;

    localparam logic [15:0] ROMSEL_ADDR = 16'hDF00;
    localparam logic [15:0] UROM_BASE   = 16'hC000;

    // The reserved encoding 3 behaves exactly like a plain READ.
    function automatic cpc_op_e decode_op(input logic [1:0] op);
        return (op == 2'd3) ? OP_READ : cpc_op_e'(op);
    endfunction

endpackage

// File: rtl/cpc_tstate_timer.sv
// Z80 T-state timer: a T_DIV down-counter flagging the first and last CLK of
// each T-state. Reloads on a state change or when the current T-state ends.
module cpc_tstate_timer #(
    parameter int T_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic reload,
    output logic start,
    output logic last
);

    localparam int CW = $clog2(T_DIV);
    localparam logic [CW-1:0] LOAD = CW'(T_DIV - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset || reload || last) begin
            cnt_q <= LOAD;
        end else begin
            cnt_q <= cnt_q - CW'(1);
        end
    end

    assign last  = (cnt_q == '0);
    assign start = (cnt_q == LOAD);

endmodule

// File: rtl/cpc_bus_initiator.sv
// Host-side Z80 bus-cycle generator for the CPC expansion connector: upper-ROM
// select writes to &DFxx and upper-ROM reads at &C000-&FFFF.
//
// state | meaning
// IDLE  | waiting for a request, req_ready high
// IO_T1 | IO write: address and data set up
// IO_T2 | IOREQ_B/WR_B asserted
// IO_TW | automatic IO wait, repeats while READY low
// IO_T3 | last IO T-state; SELREAD continues into MR_T1
// MR_T1 | memory read: address set up
// MR_T2 | MREQ_B/RD_B/ROMEN_B asserted, READY sampled at its end
// MR_TW | inserted wait, repeats while READY low
// MR_T3 | data and ROMDIS captured on its last CLK
// DONE  | strobes released, one-CLK rsp_valid
module cpc_bus_initiator
    import cpc_bus_pkg::*;
#(
    parameter int T_DIV    = 4,
    parameter int WAIT_MAX = 15
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [7:0]  req_rom,
    input  logic [13:0] req_addr,
    output logic        rsp_valid,
    output logic [7:0]  rsp_data,
    output logic        rsp_romdis,
    output logic        rsp_timeout,
    output logic [15:0] A,
    output logic [7:0]  D_OUT,
    output logic        D_OE,
    input  logic [7:0]  D_IN,
    output logic        MREQ_B,
    output logic        IOREQ_B,
    output logic        RD_B,
    output logic        WR_B,
    output logic        ROMEN_B,
    input  logic        READY,
    input  logic        ROMDIS
);

    localparam logic [3:0] WAIT_LIM = 4'(WAIT_MAX);

    cpc_state_e  state_q, state_d;
    cpc_op_e     op_q;
    logic [7:0]  rom_q;
    logic [13:0] addr_q;
    logic [3:0]  wait_q;
    logic        accept;
    logic        wait_ins;
    logic        timeout_d;
    logic        t_start;
    logic        t_last;
    logic [7:0]  rom_n;
    logic [13:0] addr_n;
    logic        io_strb_d;
    logic        mem_strb_d;
    logic        oe_d;

    cpc_tstate_timer #(.T_DIV(T_DIV)) u_timer (
        .clk    (CLK),
        .reset  (RESET),
        .reload (state_d != state_q),
        .start  (t_start),
        .last   (t_last)
    );

    assign accept = (state_q == IDLE) && req_ready && req_valid;
    assign rom_n  = accept ? req_rom  : rom_q;
    assign addr_n = accept ? req_addr : addr_q;

    always_comb begin
        state_d   = state_q;
        wait_ins  = 1'b0;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = (decode_op(req_op) == OP_READ) ? MR_T1 : IO_T1;
                end
            end
            IO_T1: if (t_last) state_d = IO_T2;
            IO_T2: if (t_last) state_d = IO_TW;
            IO_TW: begin
                if (t_last) begin
                    if (READY) begin
                        state_d = IO_T3;
                    end else if (wait_q >= WAIT_LIM) begin
                        state_d   = DONE;
                        timeout_d = 1'b1;
                    end else begin
                        wait_ins = 1'b1;
                    end
                end
            end
            IO_T3: if (t_last) state_d = (op_q == OP_SELREAD) ? MR_T1 : DONE;
            MR_T1: if (t_last) state_d = MR_T2;
            MR_T2, MR_TW: begin
                if (t_last) begin
                    if (READY) begin
                        state_d = MR_T3;
                    end else if (wait_q >= WAIT_LIM) begin
                        state_d   = DONE;
                        timeout_d = 1'b1;
                    end else begin
                        state_d  = MR_TW;
                        wait_ins = 1'b1;
                    end
                end
            end
            MR_T3: if (t_last) state_d = DONE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            op_q    <= OP_SEL;
            rom_q   <= 8'h00;
            addr_q  <= 14'h0000;
            wait_q  <= 4'h0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q   <= decode_op(req_op);
                rom_q  <= req_rom;
                addr_q <= req_addr;
            end
            // Wait budget is per bus cycle, so SELREAD starts its read afresh.
            if (state_d == IO_T1 || state_d == MR_T1) begin
                wait_q <= 4'h0;
            end else if (wait_ins && wait_q != 4'hF) begin
                wait_q <= wait_q + 4'h1;
            end
        end
    end

    assign io_strb_d  = (state_d == IO_T2) || (state_d == IO_TW) || (state_d == IO_T3);
    assign mem_strb_d = (state_d == MR_T2) || (state_d == MR_TW) || (state_d == MR_T3);
    assign oe_d       = (state_d == IO_T1) || io_strb_d;

    // Bus pins are registered from the next state so they switch on the same
    // edge as the FSM, without decode glitches on the connector.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            req_ready   <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_data    <= 8'h00;
            rsp_romdis  <= 1'b0;
            rsp_timeout <= 1'b0;
            A           <= 16'h0000;
            D_OUT       <= 8'h00;
            D_OE        <= 1'b0;
            MREQ_B      <= 1'b1;
            IOREQ_B     <= 1'b1;
            RD_B        <= 1'b1;
            WR_B        <= 1'b1;
            ROMEN_B     <= 1'b1;
        end else begin
            req_ready <= (state_d == IDLE);
            rsp_valid <= (state_d == DONE);
            D_OE      <= oe_d;
            IOREQ_B   <= !io_strb_d;
            WR_B      <= !io_strb_d;
            MREQ_B    <= !mem_strb_d;
            RD_B      <= !mem_strb_d;
            ROMEN_B   <= !mem_strb_d;
            if (state_d == IO_T1) begin
                A     <= ROMSEL_ADDR;
                D_OUT <= rom_n;
            end else if (state_d == MR_T1) begin
                A <= UROM_BASE | {2'b00, addr_n};
            end
            if (state_d == DONE) begin
                rsp_data    <= (state_q == MR_T3) ? D_IN : 8'h00;
                rsp_romdis  <= (state_q == MR_T3) && ROMDIS;
                rsp_timeout <= timeout_d;
            end
        end
    end

    a_tstate_start: assert property (@(posedge CLK) disable iff (RESET)
        (state_d != state_q) |=> t_start);

endmodule

// File: tb/tb_cpc_bus_initiator.sv
// Directed bench for cpc_bus_initiator: a table of bus requests with
// hand-computed latencies and bus observations, plus reset/back-to-back cases.
module tb_cpc_bus_initiator;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'd0;
    logic [7:0]  req_rom = 8'h00;
    logic [13:0] req_addr = 14'h0;
    logic        rsp_valid;
    logic [7:0]  rsp_data;
    logic        rsp_romdis;
    logic        rsp_timeout;
    logic [15:0] A;
    logic [7:0]  D_OUT;
    logic        D_OE;
    logic [7:0]  D_IN = 8'h00;
    logic        MREQ_B, IOREQ_B, RD_B, WR_B, ROMEN_B;
    logic        READY = 1'b1;
    logic        ROMDIS = 1'b0;

    int tests = 0;
    int fails = 0;

    always #5 CLK = ~CLK;

    cpc_bus_initiator #(.T_DIV(4), .WAIT_MAX(15)) dut (
        .CLK(CLK), .RESET(RESET),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_rom(req_rom), .req_addr(req_addr),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_romdis(rsp_romdis),
        .rsp_timeout(rsp_timeout),
        .A(A), .D_OUT(D_OUT), .D_OE(D_OE), .D_IN(D_IN),
        .MREQ_B(MREQ_B), .IOREQ_B(IOREQ_B), .RD_B(RD_B), .WR_B(WR_B), .ROMEN_B(ROMEN_B),
        .READY(READY), .ROMDIS(ROMDIS)
    );

    typedef struct {
        logic [1:0]  op;
        logic [7:0]  rom;
        logic [13:0] addr;
        logic [7:0]  din;
        logic        romdis;
        int          rdy_lo;
        int          rdy_hi;
        int          exp_lat;
        int          exp_io;
        int          exp_mem;
        logic [7:0]  exp_data;
        logic        exp_romdis;
        logic        exp_to;
        logic [15:0] exp_a;
    } vec_t;

    typedef struct {
        int          lat;
        int          io_cnt;
        int          mem_cnt;
        int          rv_cnt;
        logic [7:0]  data;
        logic        romdis;
        logic        to;
        logic [15:0] a_io;
        logic [15:0] a_mem;
        logic [7:0]  dout;
        bit          overlap;
        bit          pair_bad;
        bit          oe_bad;
        bit          done_idle;
        bit          ready_early;
        logic        ready_after;
    } res_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [4:0] strobes();
        return {MREQ_B, IOREQ_B, RD_B, WR_B, ROMEN_B};
    endfunction

    // Issue one request and watch the bus until shortly after rsp_valid.
    // lat is the edge (counted from the accept edge) at which rsp_valid is sampled.
    task automatic run_req(input vec_t v, output res_t r);
        r = '{default: 0};
        @(negedge CLK);
        req_op    = v.op;
        req_rom   = v.rom;
        req_addr  = v.addr;
        D_IN      = v.din;
        ROMDIS    = v.romdis;
        req_valid = 1'b1;
        for (int i = 0; i < 20 && !req_ready; i++) @(negedge CLK);
        @(posedge CLK);
        for (int n = 0; n < 200; n++) begin
            @(negedge CLK);
            req_valid = 1'b0;
            req_op    = 2'd0;
            req_rom   = 8'hEE;
            req_addr  = 14'h2AAA;
            READY     = (n >= v.rdy_lo && n < v.rdy_hi) ? 1'b0 : 1'b1;
            if (r.lat == 0 && req_ready) r.ready_early = 1'b1;
            if (r.lat != 0 && n == r.lat) r.ready_after = req_ready;
            if (IOREQ_B != WR_B || MREQ_B != RD_B || MREQ_B != ROMEN_B) r.pair_bad = 1'b1;
            if (!IOREQ_B && !MREQ_B) r.overlap = 1'b1;
            if (!IOREQ_B) begin
                if (r.io_cnt == 0) begin
                    r.a_io = A;
                    r.dout = D_OUT;
                end
                r.io_cnt++;
                if (!D_OE) r.oe_bad = 1'b1;
            end
            if (!MREQ_B) begin
                if (r.mem_cnt == 0) r.a_mem = A;
                r.mem_cnt++;
                if (D_OE) r.oe_bad = 1'b1;
            end
            if (rsp_valid) begin
                r.rv_cnt++;
                if (r.lat == 0) begin
                    r.lat       = n + 1;
                    r.data      = rsp_data;
                    r.romdis    = rsp_romdis;
                    r.to        = rsp_timeout;
                    r.done_idle = (strobes() == 5'h1F) && !D_OE;
                end
            end
            if (r.lat != 0 && n >= r.lat + 2) break;
        end
        READY = 1'b1;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        res_t r;
        vec_t v;
        int   cnt, bad, pulses;
        int   p_edge[2];
        logic [7:0] p_data[2];
        bit   drop;

        vecs[0] = '{op:2'd0, rom:8'h05, addr:14'h0000, din:8'hFF, romdis:1'b0, rdy_lo:0, rdy_hi:0,
                    exp_lat:17, exp_io:12, exp_mem:0, exp_data:8'h00, exp_romdis:1'b0, exp_to:1'b0, exp_a:16'h0000};
        vecs[1] = '{op:2'd1, rom:8'h00, addr:14'h0123, din:8'hA5, romdis:1'b1, rdy_lo:0, rdy_hi:0,
                    exp_lat:13, exp_io:0, exp_mem:8, exp_data:8'hA5, exp_romdis:1'b1, exp_to:1'b0, exp_a:16'hC123};
        vecs[2] = '{op:2'd1, rom:8'h00, addr:14'h0123, din:8'hA5, romdis:1'b0, rdy_lo:0, rdy_hi:0,
                    exp_lat:13, exp_io:0, exp_mem:8, exp_data:8'hA5, exp_romdis:1'b0, exp_to:1'b0, exp_a:16'hC123};
        vecs[3] = '{op:2'd3, rom:8'h00, addr:14'h3FFF, din:8'h3C, romdis:1'b1, rdy_lo:0, rdy_hi:0,
                    exp_lat:13, exp_io:0, exp_mem:8, exp_data:8'h3C, exp_romdis:1'b1, exp_to:1'b0, exp_a:16'hFFFF};
        vecs[4] = '{op:2'd2, rom:8'h0A, addr:14'h0000, din:8'h7E, romdis:1'b0, rdy_lo:20, rdy_hi:28,
                    exp_lat:37, exp_io:12, exp_mem:16, exp_data:8'h7E, exp_romdis:1'b0, exp_to:1'b0, exp_a:16'hC000};
        vecs[5] = '{op:2'd0, rom:8'h81, addr:14'h0000, din:8'h00, romdis:1'b0, rdy_lo:8, rdy_hi:12,
                    exp_lat:21, exp_io:16, exp_mem:0, exp_data:8'h00, exp_romdis:1'b0, exp_to:1'b0, exp_a:16'h0000};
        vecs[6] = '{op:2'd1, rom:8'h00, addr:14'h0040, din:8'h5A, romdis:1'b0, rdy_lo:0, rdy_hi:1000,
                    exp_lat:69, exp_io:0, exp_mem:64, exp_data:8'h00, exp_romdis:1'b0, exp_to:1'b1, exp_a:16'hC040};

        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("reset strobes", 32'(strobes()), 32'h1F);
        chk("reset A", 32'(A), 32'h0);
        chk("reset D_OUT", 32'(D_OUT), 32'h0);
        chk("reset D_OE", 32'(D_OE), 32'h0);
        chk("reset req_ready", 32'(req_ready), 32'h0);
        chk("reset rsp", 32'({rsp_valid, rsp_data, rsp_romdis, rsp_timeout}), 32'h0);
        RESET = 1'b0;
        @(negedge CLK);
        chk("ready after reset", 32'(req_ready), 32'h1);
        cnt = 0;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            if (rsp_valid) cnt++;
            if (strobes() != 5'h1F || D_OE || !req_ready) bad++;
        end
        chk("idle rsp_valid count", 32'(cnt), 32'h0);
        chk("idle bus not quiet", 32'(bad), 32'h0);

        for (int i = 0; i < 7; i++) begin
            run_req(vecs[i], r);
            chk($sformatf("v%0d latency", i), 32'(r.lat), 32'(vecs[i].exp_lat));
            chk($sformatf("v%0d io strobe clks", i), 32'(r.io_cnt), 32'(vecs[i].exp_io));
            chk($sformatf("v%0d mem strobe clks", i), 32'(r.mem_cnt), 32'(vecs[i].exp_mem));
            chk($sformatf("v%0d rsp_valid pulses", i), 32'(r.rv_cnt), 32'h1);
            chk($sformatf("v%0d rsp_data", i), 32'(r.data), 32'(vecs[i].exp_data));
            chk($sformatf("v%0d rsp_romdis", i), 32'(r.romdis), 32'(vecs[i].exp_romdis));
            chk($sformatf("v%0d rsp_timeout", i), 32'(r.to), 32'(vecs[i].exp_to));
            chk($sformatf("v%0d strobe overlap", i), 32'(r.overlap), 32'h0);
            chk($sformatf("v%0d strobe pairing", i), 32'(r.pair_bad), 32'h0);
            chk($sformatf("v%0d D_OE", i), 32'(r.oe_bad), 32'h0);
            chk($sformatf("v%0d bus idle in DONE", i), 32'(r.done_idle), 32'h1);
            chk($sformatf("v%0d ready while busy", i), 32'(r.ready_early), 32'h0);
            chk($sformatf("v%0d ready after DONE", i), 32'(r.ready_after), 32'h1);
            if (vecs[i].exp_io > 0) begin
                chk($sformatf("v%0d io A", i), 32'(r.a_io), 32'hDF00);
                chk($sformatf("v%0d io D_OUT", i), 32'(r.dout), 32'(vecs[i].rom));
            end
            if (vecs[i].exp_mem > 0) begin
                chk($sformatf("v%0d mem A", i), 32'(r.a_mem), 32'(vecs[i].exp_a));
            end
        end

        // Request held high while busy: accepted once, then again after DONE.
        @(negedge CLK);
        req_op    = 2'd1;
        req_addr  = 14'h0456;
        D_IN      = 8'h11;
        ROMDIS    = 1'b0;
        req_valid = 1'b1;
        @(posedge CLK);
        pulses = 0;
        drop   = 1'b0;
        p_edge = '{0, 0};
        p_data = '{8'h00, 8'h00};
        for (int n = 0; n < 60; n++) begin
            @(negedge CLK);
            if (n == 0) begin
                req_op  = 2'd0;
                req_rom = 8'h33;
            end
            if (drop) req_valid = 1'b0;
            if (rsp_valid) begin
                if (pulses < 2) begin
                    p_edge[pulses] = n + 1;
                    p_data[pulses] = rsp_data;
                end
                pulses++;
            end
            drop = req_valid && req_ready;
        end
        req_valid = 1'b0;
        chk("held req pulses", 32'(pulses), 32'h2);
        chk("held req first latency", 32'(p_edge[0]), 32'd13);
        chk("held req first data", 32'(p_data[0]), 32'h11);
        chk("held req second latency", 32'(p_edge[1]), 32'd31);
        chk("held req second data", 32'(p_data[1]), 32'h00);

        // Reset in the middle of IO_TW.
        @(negedge CLK);
        req_op    = 2'd0;
        req_rom   = 8'h44;
        req_valid = 1'b1;
        @(posedge CLK);
        for (int n = 0; n < 10; n++) begin
            @(negedge CLK);
            if (n == 0) req_valid = 1'b0;
        end
        chk("mid-cycle IOREQ_B before reset", 32'(IOREQ_B), 32'h0);
        RESET = 1'b1;
        @(negedge CLK);
        chk("mid reset strobes", 32'(strobes()), 32'h1F);
        chk("mid reset D_OE", 32'(D_OE), 32'h0);
        chk("mid reset rsp_valid", 32'(rsp_valid), 32'h0);
        chk("mid reset req_ready", 32'(req_ready), 32'h0);
        RESET = 1'b0;
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge CLK);
            if (rsp_valid) cnt++;
        end
        chk("no rsp after mid reset", 32'(cnt), 32'h0);
        v = '{op:2'd1, rom:8'h00, addr:14'h0200, din:8'hC3, romdis:1'b1, rdy_lo:0, rdy_hi:0,
              exp_lat:13, exp_io:0, exp_mem:8, exp_data:8'hC3, exp_romdis:1'b1, exp_to:1'b0, exp_a:16'hC200};
        run_req(v, r);
        chk("post reset latency", 32'(r.lat), 32'(v.exp_lat));
        chk("post reset data", 32'(r.data), 32'(v.exp_data));
        chk("post reset A", 32'(r.a_mem), 32'(v.exp_a));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cpc_bus_initiator.md
# cpc_bus_initiator

Synchronous Z80-style bus-cycle generator that drives the Amstrad CPC expansion connector from the host side. It issues upper-ROM select I/O writes to &DFxx and upper-ROM memory reads at &C000–&FFFF, and samples the data bus and ROMDIS. It is the initiator counterpart to the sixrom CPLD responder, used on the bench/test FPGA to exercise and read back expansion ROM boards without a real CPC.

## Interface
Parameters:
- T_DIV, 4: CLK cycles per Z80 T-state (≥2).
- WAIT_MAX, 15: maximum inserted wait T-states before the cycle is aborted with timeout.

Ports:
- **Clock and reset (already decided):** one clock, `CLK`; reset `RESET`, synchronous, active-high.
- CLK  in  1  system clock.
- RESET  in  1  synchronous active-high reset.
- req_valid  in  1  host request strobe.
- req_ready  out  1  high when IDLE; a request is accepted on an edge where req_valid & req_ready.
- req_op  in  2  0=SEL, 1=READ, 2=SELREAD, 3=reserved (accepted, treated as READ).
- req_rom  in  8  ROM number written by SEL.
- req_addr  in  14  offset within upper ROM for READ.
- rsp_valid  out  1  one-CLK completion pulse.
- rsp_data  out  8  captured D_IN (0 for SEL).
- rsp_romdis  out  1  ROMDIS sampled with data.
- rsp_timeout  out  1  cycle aborted after WAIT_MAX waits.
- A  out  16  address bus.
- D_OUT  out  8  write data.
- D_OE  out  1  data-bus output enable.
- D_IN  in  8  data bus input.
- MREQ_B, IOREQ_B, RD_B, WR_B, ROMEN_B  out  1 each  active-low strobes.
- READY  in  1  wait request (low = insert wait).
- ROMDIS  in  1  expansion ROM-disable.

## Operation
- FSM states: IDLE, IO_T1, IO_T2, IO_TW, IO_T3, MR_T1, MR_T2, MR_TW, MR_T3, DONE.
- Each non-IDLE, non-DONE state lasts one T-state, or T_DIV CLKs, counted by a T-state timer. DONE lasts 1 CLK.
- SEL goes IDLE→IO_T1→IO_T2→IO_TW→IO_T3→DONE. READ goes IDLE→MR_T1→MR_T2→MR_T3→DONE. SELREAD goes IO_T3→MR_T1 directly.
- IO cycle:
  - A=16'hDF00 and D_OUT=req_rom from IO_T1 onward.
  - D_OE=1 through IO_T3.
  - IOREQ_B=WR_B=0 in IO_T2, IO_TW, and IO_T3.
- Memory read:
  - A=16'hC000|req_addr from MR_T1.
  - MREQ_B=RD_B=ROMEN_B=0 in MR_T2, MR_TW, and MR_T3.
  - D_OE=0.
  - D_IN and ROMDIS are registered on the last CLK of MR_T3.
- Wait states: READY is sampled on the last CLK of IO_TW or MR_T2. If it is low, enter or stay in the TW state for another T-state. The wait counter is 4 bits wide and saturates.
- Timeout: when waits exceed WAIT_MAX, go to DONE with rsp_timeout=1 and rsp_data=0.
- DONE: all strobes high, D_OE=0, rsp_valid=1 for 1 CLK, then IDLE.
- Request fields are latched at accept. Later changes are ignored.

## Timing
- Reset values (next edge after RESET high): all strobes 1, A=0, D_OUT=0, D_OE=0, rsp_*=0, req_ready=0 during reset and 1 in the first CLK after it deasserts.
- Reset mid-cycle: strobes and D_OE go inactive on the next edge, and no rsp_valid is produced.
- Latency from the accept edge to rsp_valid, with no waits:
  - SEL: 4·T_DIV+1 CLKs (17 at default).
  - READ: 3·T_DIV+1 CLKs (13 at default).
  - SELREAD: 7·T_DIV+1 CLKs (29 at default).
  - Each wait adds T_DIV.
- Strobes deassert on the same edge that enters DONE. A and D_OUT are held through DONE to give one CLK of hold.
- req_ready is low from the accept edge until IDLE is re-entered. A new request can be accepted in the CLK after DONE.
- A request held during busy states is neither lost nor double-counted.

## Structure
- Package `cpc_bus_pkg` holds:
  - op encoding enum (SEL/READ/SELREAD);
  - FSM state enum;
  - constants ROMSEL_ADDR=16'hDF00 and UROM_BASE=16'hC000.
- Sub-module `cpc_tstate_timer`: a T_DIV down-counter with `start` and `last` outputs. It is reloaded on every state change.

## Test plan
- Reset then idle: all strobes 1, D_OE=0, req_ready=1 one CLK after RESET falls, and no rsp_valid for 100 CLKs.
- SEL, req_rom=8'h05:
  - A=DF00, D_OUT=05.
  - IOREQ_B=WR_B=0 for exactly 12 CLKs, with MREQ_B/RD_B held high.
  - rsp_valid at accept+17 with rsp_data=0.
- READ, req_addr=14'h0123, D_IN=A5, ROMDIS=1:
  - A=C123.
  - MREQ_B/RD_B/ROMEN_B low for 8 CLKs.
  - rsp at accept+13 with data A5 and romdis 1.
  - Repeat with ROMDIS=0 and expect rsp_romdis=0.
- SELREAD with READY low for 2 T-states in MR_T2:
  - rsp at accept+37.
  - No strobe glitch between IO_T3 and MR_T1.
- READY held low:
  - After 15 waits, rsp_timeout=1 and rsp_data=0, with all strobes high in DONE.
- Assert RESET mid-IO_TW:
  - Strobes high on the next edge, no rsp_valid.
  - A request accepted right after reset completes normally.
